// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 8x8 register file: clears r1..r(NREG-1) after reset,
// then round-robin arbitrates the single write port between ALU (A) and load (B) writeback.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_INIT | clearing registers, one per edge, readies held low
//  ST_RUN  | arbitrating A/B writebacks, one accepted write per cycle
module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              wsrc,
    output logic              init_busy
);

    localparam logic [0:0]        ST_INIT  = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              ptr;
    logic              in_run;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // ptr names the requester that wins a tie: 0 = A, 1 = B
    always_comb begin
        in_run   = (state == ST_RUN);
        a_ready  = in_run & a_valid & (~b_valid | ~ptr);
        b_ready  = in_run & b_valid & (~a_valid | ptr);
        grant    = a_ready | b_ready;
        win_addr = b_ready ? b_addr : a_addr;
        win_data = b_ready ? b_data : a_data;
    end

    assign init_busy = (state == ST_INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= FIRST_REG;
            ptr   <= 1'b0;
            we3   <= 1'b0;
            wa3   <= '0;
            wd3   <= '0;
            wsrc  <= 1'b0;
        end else if (state == ST_INIT) begin
            we3  <= 1'b1;
            wa3  <= cnt;
            wd3  <= '0;
            wsrc <= 1'b0;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_REG) begin
                state <= ST_RUN;
            end
        end else begin
            if (grant) begin
                // r0 is hard-wired zero: the request is consumed but never written
                we3  <= (win_addr != '0);
                wa3  <= win_addr;
                wd3  <= win_data;
                wsrc <= b_ready;
                ptr  <= a_ready;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: init sweep, vector table in RUN, mid-operation reset.
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready;
    logic       we3, wsrc, init_busy;
    logic [2:0] wa3;
    logic [7:0] wd3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .wsrc(wsrc), .init_busy(init_busy)
    );

    typedef struct {
        logic       av;
        logic [2:0] aa;
        logic [7:0] ad;
        logic       bv;
        logic [2:0] ba;
        logic [7:0] bd;
        logic       ar;
        logic       br;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       ws;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                                input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                                input logic ar, input logic br, input logic we,
                                input logic [2:0] wa, input logic [7:0] wd, input logic ws);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.ar = ar; v.br = br; v.we = we;
        v.wa = wa; v.wd = wd; v.ws = ws;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [2:0] ba, input logic [7:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    // Clear sequence after rst release; A is held valid the whole time
    task automatic check_init(input string tag);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            check({tag, "_we3"}, we3, 1);
            check({tag, "_wa3"}, wa3, i);
            check({tag, "_wd3"}, wd3, 0);
            check({tag, "_wsrc"}, wsrc, 0);
            check({tag, "_busy"}, init_busy, (i < 7) ? 1 : 0);
            check({tag, "_a_ready"}, a_ready, (i == 7) ? 1 : 0);
            check({tag, "_b_ready"}, b_ready, 0);
        end
    endtask

    initial begin
        // ptr after each row noted at the end
        vecs[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 8'h5A, 0); // idle, hold, ptr=1
        vecs[1]  = mk(0, 0, 8'h00, 1, 5, 8'h33, 0, 1, 1, 5, 8'h33, 1); // B only, ptr=0
        vecs[2]  = mk(1, 2, 8'h11, 1, 4, 8'h22, 1, 0, 1, 2, 8'h11, 0); // A wins, ptr=1
        vecs[3]  = mk(1, 2, 8'h12, 1, 4, 8'h22, 0, 1, 1, 4, 8'h22, 1); // B wins, ptr=0
        vecs[4]  = mk(1, 2, 8'h12, 1, 4, 8'h23, 1, 0, 1, 2, 8'h12, 0); // A wins, ptr=1
        vecs[5]  = mk(1, 2, 8'h13, 1, 4, 8'h23, 0, 1, 1, 4, 8'h23, 1); // B wins, ptr=0
        vecs[6]  = mk(1, 6, 8'h44, 0, 0, 8'h00, 1, 0, 1, 6, 8'h44, 0); // A only, ptr=1
        vecs[7]  = mk(0, 0, 8'h00, 1, 0, 8'hFF, 0, 1, 0, 0, 8'hFF, 1); // B to r0, ptr=0
        vecs[8]  = mk(1, 1, 8'h55, 1, 7, 8'h66, 1, 0, 1, 1, 8'h55, 0); // A first, ptr=1
        vecs[9]  = mk(0, 0, 8'h00, 1, 7, 8'h66, 0, 1, 1, 7, 8'h66, 1); // B pending, ptr=0
        vecs[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 7, 8'h66, 1); // idle, hold
        vecs[11] = mk(1, 0, 8'h77, 0, 0, 8'h00, 1, 0, 0, 0, 8'h77, 0); // A to r0, ptr=1
        vecs[12] = mk(1, 3, 8'h88, 1, 3, 8'h99, 0, 1, 1, 3, 8'h99, 1); // B wins, ptr=0

        rst = 1'b1;
        drive(1, 3, 8'h5A, 0, 0, 8'h00);
        #3;
        check("rst_busy", init_busy, 1);
        check("rst_we3", we3, 0);
        check("rst_wa3", wa3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_wsrc", wsrc, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        check_init("init");

        @(posedge clk); #1;
        check("single_we3", we3, 1);
        check("single_wa3", wa3, 3);
        check("single_wd3", wd3, 8'h5A);
        check("single_wsrc", wsrc, 0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            @(negedge clk);
            check($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ar);
            check($sformatf("v%0d_b_ready", i), b_ready, vecs[i].br);
            @(posedge clk); #1;
            check($sformatf("v%0d_we3", i), we3, vecs[i].we);
            check($sformatf("v%0d_wa3", i), wa3, vecs[i].wa);
            check($sformatf("v%0d_wd3", i), wd3, vecs[i].wd);
            check($sformatf("v%0d_wsrc", i), wsrc, vecs[i].ws);
        end

        // Mid-operation reset with a write registered and A still pending
        drive(1, 2, 8'hAB, 0, 0, 8'h00);
        @(negedge clk);
        check("mid_pre_a_ready", a_ready, 1);
        @(posedge clk); #1;
        check("mid_pre_we3", we3, 1);
        check("mid_pre_wa3", wa3, 2);
        drive(1, 6, 8'hCD, 0, 0, 8'h00);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_we3", we3, 0);
        check("mid_rst_a_ready", a_ready, 0);
        check("mid_rst_busy", init_busy, 1);
        check("mid_rst_wa3", wa3, 0);
        @(negedge clk);
        rst = 1'b0;

        check_init("reinit");

        @(posedge clk); #1;
        check("after_we3", we3, 1);
        check("after_wa3", wa3, 6);
        check("after_wd3", wd3, 8'hCD);
        check("after_wsrc", wsrc, 0);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("after_idle_we3", we3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, limit 20000 reached");
        $fatal(1);
    end

endmodule
